// File: rtl/pipe_stage_skid.sv
`default_nettype none
// =============================================================================
// pipe_stage_skid: valid/ready pipeline stage register, optional 2-entry skid
// buffer, flush, saturating stall/bubble counters.            Revision: 1.0
// =============================================================================
module pipe_stage_skid #(
   parameter int DATA_W = 128,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] main_nxt;
   logic [DATA_W-1:0] skid_q;
   logic [DATA_W-1:0] skid_nxt;
   logic              in_xfer;
   logic              out_xfer;

   assign out_valid = (state != EMPTY);
   assign out_data  = main_q;
   assign occupancy = state;
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state  <= EMPTY;
         main_q <= '0;
      end else begin
         state  <= state_nxt;
         main_q <= main_nxt;
      end
   end

   // Empty slots are always zeroed so out_data reads 0 whenever out_valid=0.
   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      if (flush) begin
         state_nxt = EMPTY;
         main_nxt  = '0;
         skid_nxt  = '0;
      end else begin
         case (state)
            EMPTY: begin
               if (in_xfer) begin
                  state_nxt = ONE;
                  main_nxt  = in_data;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  main_nxt = in_data;
               end else if (in_xfer) begin
                  // Unreachable without the skid buffer: in_ready implies out_ready.
                  state_nxt = FULL;
                  skid_nxt  = in_data;
               end else if (out_xfer) begin
                  state_nxt = EMPTY;
                  main_nxt  = '0;
               end
            end
            FULL: begin
               if (out_xfer) begin
                  state_nxt = ONE;
                  main_nxt  = skid_q;
                  skid_nxt  = '0;
               end
            end
            default: begin
               state_nxt = EMPTY;
               main_nxt  = '0;
               skid_nxt  = '0;
            end
         endcase
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         logic rdy_q;

         always_ff @(posedge clk) begin
            if (!resetn) begin
               skid_q <= '0;
               rdy_q  <= 1'b0;
            end else begin
               skid_q <= skid_nxt;
               rdy_q  <= (state_nxt != FULL);
            end
         end

         assign in_ready = rdy_q;
      end else begin : g_noskid
         assign skid_q   = '0;
         assign in_ready = resetn & (~out_valid | out_ready);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!resetn || clr_cnt) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         if (!out_valid && out_ready && bubble_cnt != CNT_MAX) begin
            bubble_cnt <= bubble_cnt + CNT_ONE;
         end
      end
   end

endmodule
`default_nettype wire
